aes_enc_iter: RTL
=================

# aes_enc_iter

Iterative AES-128 encryption engine: one round per clock, with the round key expanded on the fly from the cipher key. It is the forward-direction companion to the decryption core. Together they form the Pass-Keeper crypto path: this block encrypts stored secrets and the decryption core recovers them. It uses the same start/busy/done handshake and the same 128-bit big-endian data convention (bits 127:120 = byte 0).

## Interface
- No parameters. AES-128 only: 10 rounds, 128-bit key.
- clk  in  1  system clock; all state updates on the rising edge.
- rest  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- plaintext  in  128  input block; captured on the accepting edge.
- local_key  in  128  cipher key; captured on the accepting edge.
- cipher_text  out  128  result; holds until the next completion.
- done  out  1  one-cycle pulse marking a valid cipher_text.
- busy  out  1  high while a block is in flight.

## Operation
- Registers:
  - st: 128-bit cipher state.
  - rk: 128-bit current round key.
  - rnd: 4-bit round counter.
  - fsm: IDLE / RUN.
- IDLE:
  - Leaves IDLE when start=1. This edge is the accept edge.
  - On accept: st <= plaintext ^ local_key, rk <= local_key, rnd <= 1, busy <= 1, fsm <= RUN.
- RUN, each edge:
  - rk_n = expand(rk, rcon[rnd]): RotWord, SubWord, rcon XOR on word 0, then the chained XOR of words 1–3.
  - st <= round(st, rk_n, last = (rnd==10)).
  - A round is SubBytes, ShiftRows, MixColumns, then AddRoundKey; MixColumns is skipped when last=1.
  - rk <= rk_n, rnd <= rnd+1.
- Completion, on the rnd==10 edge:
  - cipher_text <= round result, done <= 1, busy <= 0, fsm <= IDLE.
- rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, indexed by rnd 1..10.
- GF(2^8) arithmetic: xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0). MixColumns uses only xtime and XOR.
- start while busy=1 is ignored; plaintext and local_key are not re-sampled.
- done is cleared on every edge where it is not being set.

## Timing
- Reset values:
  - cipher_text = 0, done = 0, busy = 0, fsm = IDLE, rnd = 0.
  - st and rk = 0.
- Accept edge E0 sets busy=1. Rounds execute on edges E1..E10.
- done=1 and busy=0 are visible in the cycle after E10, i.e. 10 cycles after the accept edge.
- Back-to-back operation: start held high during the done cycle is accepted on that edge, since busy=0 there. Sustained throughput is one block per 11 cycles.
- Reset mid-operation (rest=1 on any edge) wins over all other activity:
  - The block in flight is aborted; no done pulse is issued.
  - All outputs return to their reset values on that edge.
- If rest and start are both high on the same edge, start is dropped.
- rnd never wraps: it only counts 1..10 within RUN.

## Configuration
- Macro: AES_ENC_UNROLL2_EN.
- Defined:
  - Two round instances are chained per cycle; rnd advances by 2 on each edge.
  - last applies to the second instance when rnd==9.
  - Rounds execute on E1..E5, and done appears 5 cycles after the accept edge.
- Undefined: one round per cycle, with the behaviour and timing stated above.
- Ports, reset values and handshake rules are identical in both builds.

## Structure
- Package aes_enc_pkg:
  - sbox[256] constant.
  - rcon[1..10] constant.
  - xtime function.
  - fsm state enum (IDLE, RUN).
  - AES_ROUNDS = 10.
- Sub-module aes_enc_round:
  - Combinational: inputs state, round_key, last; output next_state.
  - Instanced once, or twice under AES_ENC_UNROLL2_EN.
- The key-expansion step stays in the top module as a package function.

## Test plan
- FIPS-197 App. B:
  - Stimulus: local_key=2b7e151628aed2a6abf7158809cf4f3c, plaintext=3243f6a8885a308d313198a2e0370734.
  - Response: cipher_text=3925841d02dc09fbdc118597196a0b32, done after exactly 10 cycles (5 with AES_ENC_UNROLL2_EN).
- FIPS-197 App. C.1:
  - Stimulus: local_key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff.
  - Response: cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a.
- Start while busy:
  - Stimulus: pulse start with different data at cycle 4 of an App. B run.
  - Response: result is unchanged, exactly one done pulse, busy does not re-extend.
- Back-to-back:
  - Stimulus: hold start=1 continuously with App. B data, then App. C.1 data.
  - Response: two done pulses 11 cycles apart with the correct ciphertexts.
- Reset mid-run:
  - Stimulus: rest=1 at cycle 6 of a run.
  - Response: the next edge gives busy=0, done=0, cipher_text=0, and no done pulse follows.
- Round-trip:
  - Stimulus: feed the App. B ciphertext with the same key into the decryption core.
  - Response: plaintext 3243f6a8885a308d313198a2e0370734 is recovered.

Source files
------------

// File: rtl/aes_enc_pkg.sv
// Shared constants and helpers for the iterative AES-128 encryption engine:
// S-box, round constants, GF(2^8) xtime, on-the-fly key expansion, FSM states.
package aes_enc_pkg;

  localparam int AES_ROUNDS = 10;

  typedef enum logic {IDLE, RUN} fsm_t;

  // Entry 0 sits in the most significant byte, so SBOX[b] is a direct lookup.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Indexed directly by the 4-bit round counter; slots 0 and 11..15 are unused.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // One AES-128 key-schedule step: RotWord, SubWord and rcon on word 0, then chained XOR.
  function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {sub_byte(w3[23:16]), sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])}
         ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (bypassed on the last round) and AddRoundKey.
module aes_enc_round
  import aes_enc_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] next_state
);

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [127:0] shifted;
  logic [127:0] mixed;

  // Byte i is bits 127-8i; row r of column c reads column (c+r)%4 of the input.
  // NOTE: every combinational output gets a full default first so no path can infer a latch.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = sub_byte(state[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
  end

  assign next_state = (last ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption, one round per clock with on-the-fly key expansion.
// Define AES_ENC_UNROLL2_EN to chain two rounds per clock (done 5 cycles after accept).
module aes_enc_iter
  import aes_enc_pkg::*;
(
  input  logic         clk,
  input  logic         rest,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] local_key,
  output logic [127:0] cipher_text,
  output logic         done,
  output logic         busy
);

  fsm_t         fsm, fsm_n;
  logic [127:0] st, st_n;
  logic [127:0] rk, rk_n;
  logic [3:0]   rnd, rnd_n;
  logic [127:0] ct_n;
  logic         done_n;

  logic [127:0] round_out;
  logic [127:0] key_out;
  logic         final_round;

`ifdef AES_ENC_UNROLL2_EN
  localparam logic [3:0] RND_STEP = 4'd2;
  logic [127:0] mid_state;
  logic [127:0] mid_key;

  assign mid_key     = expand_key(rk, RCON[rnd]);
  assign key_out     = expand_key(mid_key, RCON[rnd + 4'd1]);
  assign final_round = (rnd == 4'(AES_ROUNDS - 1));

  aes_enc_round u_round0 (
    .state      (st),
    .round_key  (mid_key),
    .last       (1'b0),
    .next_state (mid_state)
  );

  aes_enc_round u_round1 (
    .state      (mid_state),
    .round_key  (key_out),
    .last       (final_round),
    .next_state (round_out)
  );
`else
  localparam logic [3:0] RND_STEP = 4'd1;

  assign key_out     = expand_key(rk, RCON[rnd]);
  assign final_round = (rnd == 4'(AES_ROUNDS));

  aes_enc_round u_round (
    .state      (st),
    .round_key  (key_out),
    .last       (final_round),
    .next_state (round_out)
  );
`endif

  assign busy = (fsm == RUN);

  always_comb begin
    fsm_n  = fsm;
    st_n   = st;
    rk_n   = rk;
    rnd_n  = rnd;
    ct_n   = cipher_text;
    done_n = 1'b0;
    case (fsm)
      IDLE: begin
        if (start) begin
          st_n  = plaintext ^ local_key;
          rk_n  = local_key;
          rnd_n = 4'd1;
          fsm_n = RUN;
        end
      end
      RUN: begin
        st_n  = round_out;
        rk_n  = key_out;
        rnd_n = rnd + RND_STEP;
        if (final_round) begin
          // Park the counter at 0 so it never leaves 1..10 while running.
          rnd_n  = 4'd0;
          ct_n   = round_out;
          done_n = 1'b1;
          fsm_n  = IDLE;
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  // NOTE: reset is synchronous (sampled on the edge) and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rest) begin
      fsm         <= IDLE;
      st          <= '0;
      rk          <= '0;
      rnd         <= '0;
      cipher_text <= '0;
      done        <= 1'b0;
    end else begin
      fsm         <= fsm_n;
      st          <= st_n;
      rk          <= rk_n;
      rnd         <= rnd_n;
      cipher_text <= ct_n;
      done        <= done_n;
    end
  end

endmodule
